// File: rtl/vga_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two sprite controllers.
// Each issued read carries a tag down a latency-matched pipeline that routes returned data to its issuer.
module vga_rom_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } owner_t;

    // Stage 0 lines up with rom_addr; the last stage lines up with rom_data.
    localparam int STAGES = ROM_LAT + 1;

    owner_t              last;
    logic [STAGES-1:0]   tag_valid;
    owner_t              tag_id [STAGES];
    logic [15:0]         cnt;

    assign conflict_cnt = cnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || last == REQ1)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= REQ1;
            rom_addr  <= '0;
            tag_valid <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            cnt       <= '0;
        end else begin
            if (gnt0) begin
                last     <= REQ0;
                rom_addr <= addr0;
            end else if (gnt1) begin
                last     <= REQ1;
                rom_addr <= addr1;
            end

            tag_valid <= {tag_valid[STAGES-2:0], gnt0 | gnt1};

            rvalid0 <= tag_valid[STAGES-1] && (tag_id[STAGES-1] == REQ0);
            rvalid1 <= tag_valid[STAGES-1] && (tag_id[STAGES-1] == REQ1);
            if (tag_valid[STAGES-1] && tag_id[STAGES-1] == REQ0) begin
                rdata0 <= rom_data;
            end
            if (tag_valid[STAGES-1] && tag_id[STAGES-1] == REQ1) begin
                rdata1 <= rom_data;
            end

            if (req0 && req1 && cnt != '1) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Ids need no reset: they are only consumed alongside a set valid bit.
    always_ff @(posedge clk) begin
        tag_id[0] <= gnt1 ? REQ1 : REQ0;
        for (int unsigned i = 1; i < STAGES; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Bench for vga_rom_arbiter: ROM stubs with mem[n]=n[7:0], a transaction-level reference
// model (grant rule plus a return queue keyed by due cycle), directed and random scenarios.
module tb_vga_rom_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int LAT   = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, req1, gnt0, gnt1, rvalid0, rvalid1;
    logic [AW-1:0] addr0, addr1, rom_addr;
    logic [DW-1:0] rdata0, rdata1, rom_data;
    logic [15:0]   conflict_cnt;

    logic          b_rst, b_req0, b_req1, b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [AW-1:0] b_addr0, b_addr1, b_rom_addr;
    logic [DW-1:0] b_rdata0, b_rdata1, b_rom_data;
    logic [15:0]   b_conflict_cnt;

    vga_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .rom_addr(rom_addr), .rom_data(rom_data), .conflict_cnt(conflict_cnt)
    );

    vga_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(b_rst),
        .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .rdata0(b_rdata0), .rvalid0(b_rvalid0),
        .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .rdata1(b_rdata1), .rvalid1(b_rvalid1),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .conflict_cnt(b_conflict_cnt)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rom_q;
    logic [DW-1:0] rom_b_q [LAT_B];

    always @(posedge clk) begin
        rom_q      <= mem[rom_addr];
        rom_b_q[0] <= mem[b_rom_addr];
        for (int i = 1; i < LAT_B; i++) rom_b_q[i] <= rom_b_q[i-1];
    end
    assign rom_data   = rom_q;
    assign b_rom_data = rom_b_q[LAT_B-1];

    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          pend[$];
    int            cyc;
    bit            m_last;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rd0, m_rd1;
    bit            m_rv0, m_rv1;
    int            n_cmp, n_bad;

    function automatic bit win0();
        return !rst && req0 && (!req1 || m_last);
    endfunction

    function automatic bit win1();
        return !rst && req1 && (!req0 || !m_last);
    endfunction

    function automatic logic [46:0] expv();
        return {win0(), win1(), m_rv0, m_rv1, m_rd0, m_rd1, m_addr, m_cnt};
    endfunction

    function automatic logic [46:0] obs();
        return {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr, conflict_cnt};
    endfunction

    task automatic set_in(input logic r, input logic q0, input logic [AW-1:0] a0,
                          input logic q1, input logic [AW-1:0] a1);
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
    endtask

    // Advance one clock; the model applies the transaction rules to the inputs of the ending cycle.
    task automatic step();
        bit g0, g1;
        g0 = win0();
        g1 = win1();
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_last = 1'b1; m_cnt = '0; m_addr = '0; m_rd0 = '0; m_rd1 = '0;
        end else begin
            if (req0 && req1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (g0 || g1) begin
                m_last = g1;
                m_addr = g1 ? addr1 : addr0;
                pend.push_back('{cyc + LAT + 2, g1, mem[m_addr]});
            end
        end
        cyc++;
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].id) begin m_rv1 = 1'b1; m_rd1 = pend[0].data; end
            else            begin m_rv0 = 1'b1; m_rd0 = pend[0].data; end
            void'(pend.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL reset[%0d]: got %h required %h", i, obs(), expv());
            end
            n_cmp++;
            if ({gnt0, gnt1, rvalid0, rvalid1, rom_addr, conflict_cnt} !== '0) begin
                n_bad++; $display("FAIL reset_zero[%0d]: got %b%b%b%b %h %h required all zero",
                                  i, gnt0, gnt1, rvalid0, rvalid1, rom_addr, conflict_cnt);
            end
            step();
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, i == 0, 11'h005, 1'b0, '0);
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL single[%0d]: got %h required %h", i, obs(), expv());
            end
            if (i == 0) begin
                n_cmp++;
                if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL single_gnt: got %b required 1", gnt0); end
            end
            if (i == 1) begin
                n_cmp++;
                if (rom_addr !== 11'h005) begin n_bad++; $display("FAIL single_addr: got %h required 005", rom_addr); end
            end
            if (i == 3) begin
                n_cmp++;
                if (rvalid0 !== 1'b1 || rdata0 !== 8'h05) begin
                    n_bad++; $display("FAIL single_ret: got rvalid0=%b rdata0=%h required 1/05", rvalid0, rdata0);
                end
            end
            n_cmp++;
            if (rvalid1 !== 1'b0) begin n_bad++; $display("FAIL single_rv1[%0d]: got %b required 0", i, rvalid1); end
            step();
        end
    endtask

    task automatic test_tie();
        logic [AW-1:0] a0, a1;
        bit g0;
        a0 = AW'($urandom);
        a1 = AW'($urandom);
        for (int i = 0; i < 12; i++) begin
            int k;
            k = i - 1;
            set_in(i == 0, k >= 0 && k < 8, a0, k >= 0 && k < 8, a1);
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL tie[%0d]: got %h required %h", k, obs(), expv());
            end
            if (k >= 0 && k < 8) begin
                n_cmp++;
                if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                    n_bad++; $display("FAIL tie_gnt[%0d]: got %b%b required %b%b", k, gnt0, gnt1, k % 2 == 0, k % 2 == 1);
                end
            end
            if (k >= 0 && k <= 8) begin
                n_cmp++;
                if (conflict_cnt !== 16'(k)) begin
                    n_bad++; $display("FAIL tie_cnt[%0d]: got %0d required %0d", k, conflict_cnt, k);
                end
            end
            if (k >= 3) begin
                n_cmp++;
                if (rvalid0 !== (k % 2 == 1) || rvalid1 !== (k % 2 == 0)) begin
                    n_bad++; $display("FAIL tie_rv[%0d]: got %b%b required %b%b", k, rvalid0, rvalid1, k % 2 == 1, k % 2 == 0);
                end
            end
            g0 = win0();
            step();
            if (k >= 0 && k < 8) begin
                if (g0) a0 = AW'($urandom);
                else    a1 = AW'($urandom);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            int j;
            j = i - 4;
            set_in(1'b0, 1'b0, '0, j >= 0 && j < 4, AW'(11'h100 + j));
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL b2b[%0d]: got %h required %h", j, obs(), expv());
            end
            n_cmp++;
            if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt0[%0d]: got %b required 0", j, gnt0); end
            if (j >= 3 && j < 7) begin
                n_cmp++;
                if (rvalid1 !== 1'b1 || rdata1 !== 8'(j - 3)) begin
                    n_bad++; $display("FAIL b2b_ret[%0d]: got %b/%h required 1/%h", j, rvalid1, rdata1, 8'(j - 3));
                end
            end
            step();
        end
    endtask

    task automatic test_withdraw();
        int nv0, nv1;
        bit bad_addr;
        nv0 = 0; nv1 = 0; bad_addr = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4)      set_in(1'b0, 1'b1, 11'h010, 1'b0, '0);
            else if (i == 5) set_in(1'b0, 1'b1, 11'h7AA, 1'b1, 11'h020);
            else             set_in(1'b0, 1'b0, '0, 1'b0, '0);
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL withdraw[%0d]: got %h required %h", i, obs(), expv());
            end
            if (i >= 4) begin
                nv0 += int'(rvalid0);
                nv1 += int'(rvalid1);
                if (rom_addr === 11'h7AA) bad_addr = 1;
            end
            step();
        end
        n_cmp++;
        if (nv0 !== 1 || nv1 !== 1) begin
            n_bad++; $display("FAIL withdraw_count: got rvalid0 x%0d rvalid1 x%0d required 1 and 1", nv0, nv1);
        end
        n_cmp++;
        if (bad_addr) begin n_bad++; $display("FAIL withdraw_addr: got rom_addr 7AA required never"); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 13; i++) begin
            if (i == 4)      set_in(1'b0, 1'b1, 11'h033, 1'b0, '0);
            else if (i == 5) set_in(1'b1, 1'b0, '0, 1'b0, '0);
            else if (i == 8) set_in(1'b0, 1'b1, 11'h044, 1'b1, 11'h055);
            else             set_in(1'b0, 1'b0, '0, 1'b0, '0);
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL midrst[%0d]: got %h required %h", i, obs(), expv());
            end
            if (i == 6) begin
                n_cmp++;
                if ({rom_addr, rdata0, rdata1, rvalid0, rvalid1, conflict_cnt} !== '0) begin
                    n_bad++; $display("FAIL midrst_vals: got %h %h %h %b%b %h required zeros",
                                      rom_addr, rdata0, rdata1, rvalid0, rvalid1, conflict_cnt);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (rvalid0 !== 1'b0) begin n_bad++; $display("FAIL midrst_discard: got rvalid0=%b required 0", rvalid0); end
            end
            if (i == 8) begin
                n_cmp++;
                if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                    n_bad++; $display("FAIL midrst_tie: got %b%b required 10", gnt0, gnt1);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        bit act0, act1, g0, g1;
        logic [AW-1:0] a0, a1;
        act0 = 0; act1 = 0; g0 = 0; g1 = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!act0 || g0) begin act0 = ($urandom_range(0, 3) != 0); a0 = AW'($urandom); end
            else if ($urandom_range(0, 15) == 0) act0 = 0;
            if (!act1 || g1) begin act1 = ($urandom_range(0, 3) != 0); a1 = AW'($urandom); end
            else if ($urandom_range(0, 15) == 0) act1 = 0;
            set_in($urandom_range(0, 49) == 0, act0, a0, act1, a1);
            #1;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL random[%0d]: got %h required %h", i, obs(), expv());
            end
            g0 = win0();
            g1 = win1();
            step();
        end
    endtask

    task automatic test_saturation();
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        step();
        for (int i = 0; i < 65538; i++) begin
            set_in(1'b0, 1'b1, 11'h0AB, 1'b1, 11'h0CD);
            #1;
            if (i >= 65530) begin
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL sat[%0d]: got %h required %h", i, obs(), expv());
                end
            end
            if (i >= 65534) begin
                n_cmp++;
                if (conflict_cnt !== ((i == 65534) ? 16'hFFFE : 16'hFFFF)) begin
                    n_bad++; $display("FAIL sat_cnt[%0d]: got %h required %h", i, conflict_cnt,
                                      (i == 65534) ? 16'hFFFE : 16'hFFFF);
                end
            end
            step();
        end
    endtask

    task automatic test_latency3();
        logic [AW-1:0] ra;
        ra = AW'($urandom);
        for (int i = 0; i < 11; i++) begin
            set_in(1'b0, 1'b0, '0, 1'b0, '0);
            b_rst   = (i == 0);
            b_req0  = (i == 2 || i == 3);
            b_addr0 = (i == 2) ? 11'h005 : ra;
            b_req1  = 1'b0;
            b_addr1 = '0;
            #1;
            n_cmp++;
            if (b_gnt0 !== (i == 2 || i == 3) || b_gnt1 !== 1'b0) begin
                n_bad++; $display("FAIL lat3_gnt[%0d]: got %b%b required %b0", i, b_gnt0, b_gnt1, i == 2 || i == 3);
            end
            n_cmp++;
            if (b_rvalid0 !== (i == 7 || i == 8) || b_rvalid1 !== 1'b0) begin
                n_bad++; $display("FAIL lat3_rv[%0d]: got %b%b required %b0", i, b_rvalid0, b_rvalid1, i == 7 || i == 8);
            end
            if (i == 7) begin
                n_cmp++;
                if (b_rdata0 !== 8'h05) begin n_bad++; $display("FAIL lat3_data0: got %h required 05", b_rdata0); end
            end
            if (i == 8) begin
                n_cmp++;
                if (b_rdata0 !== mem[ra]) begin n_bad++; $display("FAIL lat3_data1: got %h required %h", b_rdata0, mem[ra]); end
            end
            step();
        end
    endtask

    initial begin
        for (int n = 0; n < (1 << AW); n++) mem[n] = DW'(n);
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_last = 1'b1; m_cnt = '0; m_addr = '0; m_rd0 = '0; m_rd1 = '0; m_rv0 = 0; m_rv1 = 0;
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        b_rst = 1'b1; b_req0 = 1'b0; b_addr0 = '0; b_req1 = 1'b0; b_addr1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_withdraw();
        test_reset_midflight();
        test_random();
        test_saturation();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
